// File: rtl/fifo_pkg.sv
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared defaults and helpers for the async FIFO read-side packer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DATA_W_DEF    = 3;
  localparam int PACK_N_DEF    = 4;
  localparam int FRAME_LEN_DEF = 2;

  // Lane-fill counter must represent 0..PACK_N inclusive.
  function automatic int fcnt_width(input int pack_n);
    return $clog2(pack_n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_frame_cnt.sv
// ============================================================================
// Module : fifo_frame_cnt
// Brief  : Wrapping frame counter; flags the last packed word of each frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_frame_cnt
  import fifo_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic clk_r,
  input  logic rst_r,
  input  logic inc,
  output logic last
);

  localparam int            CW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] C_TOP = CW'(FRAME_LEN - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = (cnt_q == C_TOP) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Look ahead past an acceptance in this cycle so a word loaded on the same
  // edge its predecessor leaves is positioned correctly within the frame.
  assign last = (cnt_d == C_TOP);

endmodule

`default_nettype wire

// File: rtl/fifo_rd_packer.sv
// ============================================================================
// Module : fifo_rd_packer
// Brief  : Drains the async FIFO read side, packs PACK_N words per output beat.
//          Define PACKER_LAST_EN to enable frame marking on m_last.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PACK_N    = PACK_N_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                     clk_r,
  input  logic                     rst_r,
  input  logic                     empty,
  output logic                     r_en,
  input  logic [DATA_W-1:0]        data_out,
  output logic [DATA_W*PACK_N-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  localparam int           FW     = fcnt_width(PACK_N);
  localparam int           MW     = DATA_W * PACK_N;
  localparam logic [FW:0]  C_FULL = (FW + 1)'(PACK_N);

  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              rd_pend_q;
  logic [DATA_W-1:0] acc_q [PACK_N];
  logic [DATA_W-1:0] acc_d [PACK_N];
  logic [MW-1:0]     m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;

  logic [FW:0]       w_fill;
  logic              w_xfer;
  logic              w_accept;
  logic              w_frm_last;

  if (PACK_N < 2 || FRAME_LEN < 1) begin : g_param_chk
    $error("fifo_rd_packer: PACK_N must be >= 2 and FRAME_LEN >= 1");
  end

  // Fill level including the lane landing this cycle, so the final capture and
  // the transfer share one edge.
  assign w_fill   = {1'b0, fcnt_q} + {{FW{1'b0}}, rd_pend_q};
  assign r_en     = !rst_r && !empty && (w_fill < C_FULL);
  assign w_xfer   = (w_fill == C_FULL) && (!m_valid_q || m_ready);
  assign w_accept = m_valid_q && m_ready;

  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < PACK_N; i++) begin
      if (rd_pend_q && (fcnt_q == FW'(i))) begin
        acc_d[i] = data_out;
      end
    end

    fcnt_d    = w_xfer ? '0 : w_fill[FW-1:0];
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;

    if (w_xfer) begin
      for (int i = 0; i < PACK_N; i++) begin
        m_data_d[i*DATA_W +: DATA_W] = acc_d[i];
      end
      m_valid_d = 1'b1;
      m_last_d  = w_frm_last;
    end else if (w_accept) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      fcnt_q    <= '0;
      rd_pend_q <= 1'b0;
      for (int i = 0; i < PACK_N; i++) begin
        acc_q[i] <= '0;
      end
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      fcnt_q    <= fcnt_d;
      rd_pend_q <= r_en;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

`ifdef PACKER_LAST_EN
  fifo_frame_cnt #(
    .FRAME_LEN (FRAME_LEN)
  ) u_frame_cnt (
    .clk_r (clk_r),
    .rst_r (rst_r),
    .inc   (w_accept),
    .last  (w_frm_last)
  );
`else
  assign w_frm_last = 1'b0;
`endif

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

endmodule

`default_nettype wire
